task_feeder: RTL and testbench



---
 rtl/task_pkg.sv | 37 +++
 rtl/task_track_table.sv | 73 +++++++
 rtl/task_feeder.sv | 141 ++++++++++++++
 tb/tb_task_feeder.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/task_pkg.sv
// Shared types and sizing for the scheduler front end: task payload, tracking entry, FSM state.
package task_pkg;

    localparam int unsigned SLOTS   = 5;
    localparam int unsigned ID_W    = 16;
    localparam int unsigned BURST_W = 4;
    localparam int unsigned TASK_W  = ID_W + BURST_W;
    localparam int unsigned CRED_W  = 3;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned DROP_W  = 8;

    localparam logic [ID_W-1:0] IDLE_ID = 16'hFFFF;

    typedef struct packed {
        logic [BURST_W-1:0] burst;
        logic [ID_W-1:0]    id;
    } task_t;

    typedef struct packed {
        logic               valid;
        logic [ID_W-1:0]    id;
        logic [BURST_W-1:0] rem;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        RUN
    } state_t;

    // A zero-length task or one carrying the idle marker can never be tracked.
    function automatic logic task_legal(input task_t t);
        return (t.burst != '0) && (t.id != IDLE_ID);
    endfunction

endpackage

// File: rtl/task_track_table.sv
// In-flight task table: id CAM, lowest-free allocation, per-slice decrement and release.
module task_track_table
    import task_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_alloc,
    input  task_t           i_alloc_task,
    input  logic [ID_W-1:0] i_query_id,
    input  logic            i_obs_valid,
    input  logic [ID_W-1:0] i_obs_id,
    output logic            o_hit_c,
    output logic            o_obs_hit_c,
    output logic            o_free_c,
    output logic [ID_W-1:0] o_free_id_c,
    output logic            o_all_free_c
);

    entry_t           r_tab [SLOTS];
    logic             w_has_free;
    logic [IDX_W-1:0] w_alloc_idx;

    // Ids are unique among valid entries, so at most one entry matches either lookup.
    always_comb begin
        o_hit_c      = 1'b0;
        o_obs_hit_c  = 1'b0;
        o_free_c     = 1'b0;
        o_free_id_c  = '0;
        o_all_free_c = 1'b1;
        w_has_free   = 1'b0;
        w_alloc_idx  = '0;
        for (int unsigned i = 0; i < SLOTS; i++) begin
            if (r_tab[i].valid) begin
                o_all_free_c = 1'b0;
                if (r_tab[i].id == i_query_id) begin
                    o_hit_c = 1'b1;
                end
                if (i_obs_valid && (r_tab[i].id == i_obs_id)) begin
                    o_obs_hit_c = 1'b1;
                    if (r_tab[i].rem == BURST_W'(1)) begin
                        o_free_c    = 1'b1;
                        o_free_id_c = r_tab[i].id;
                    end
                end
            end else if (!w_has_free) begin
                w_has_free  = 1'b1;
                w_alloc_idx = IDX_W'(i);
            end
        end
    end

    // Allocation only targets an entry that was free before this edge, so it never collides with a release.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < SLOTS; i++) begin
                r_tab[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < SLOTS; i++) begin
                if (i_obs_valid && r_tab[i].valid && (r_tab[i].id == i_obs_id) && (r_tab[i].rem != '0)) begin
                    r_tab[i].rem <= r_tab[i].rem - BURST_W'(1);
                    if (r_tab[i].rem == BURST_W'(1)) begin
                        r_tab[i].valid <= 1'b0;
                    end
                end
                if (i_alloc && w_has_free && (w_alloc_idx == IDX_W'(i))) begin
                    r_tab[i] <= '{valid: 1'b1, id: i_alloc_task.id, rem: i_alloc_task.burst};
                end
            end
        end
    end

endmodule

// File: rtl/task_feeder.sv
// Producer-side front end: starts the scheduler, meters tasks into its store by credit,
// tracks every in-flight task from the slice stream and reports completions.
module task_feeder
    import task_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [TASK_W-1:0] in_task,
    output logic              sch_st,
    output logic              sch_inputtask,
    output logic [TASK_W-1:0] sch_task_in,
    input  logic [ID_W-1:0]   sch_task_out,
    input  logic              sch_empty,
    output logic              done_valid,
    output logic [ID_W-1:0]   done_id,
    output logic [CRED_W-1:0] credits,
    output logic [DROP_W-1:0] drop_cnt,
    output logic              err
);

    state_t              r_state;
    logic                r_sch_st;
    logic                r_sch_inputtask;
    logic [TASK_W-1:0]   r_sch_task_in;
    logic                r_done_valid;
    logic [ID_W-1:0]     r_done_id;
    logic [CRED_W-1:0]   r_credits;
    logic [DROP_W-1:0]   r_drop_cnt;
    logic                r_err;
    logic                r_idle_seen;

    task_t               w_task;
    logic                w_run;
    logic                w_legal;
    logic                w_hit;
    logic                w_drop;
    logic                w_issue;
    logic                w_obs;
    logic                w_obs_hit;
    logic                w_free;
    logic [ID_W-1:0]     w_free_id;
    logic                w_all_free;
    logic                w_idle_cond;

    assign w_task   = task_t'(in_task);
    assign w_run    = (r_state == RUN);
    assign w_legal  = task_legal(w_task);
    assign w_drop   = w_run && in_valid && !w_legal;
    // Duplicate in-flight ids are held at the head until the earlier instance retires.
    assign w_issue  = w_run && in_valid && w_legal && (r_credits != '0) && !w_hit;
    assign in_ready = w_drop || w_issue;
    assign w_obs    = w_run && (sch_task_out != IDLE_ID);
    // Scheduler claims work while nothing is tracked and nothing is being written to it.
    assign w_idle_cond = w_run && w_all_free && !r_sch_inputtask && !sch_empty;

    task_track_table u_table (
        .clk          (clk),
        .rst          (rst),
        .i_alloc      (w_issue),
        .i_alloc_task (w_task),
        .i_query_id   (w_task.id),
        .i_obs_valid  (w_obs),
        .i_obs_id     (sch_task_out),
        .o_hit_c      (w_hit),
        .o_obs_hit_c  (w_obs_hit),
        .o_free_c     (w_free),
        .o_free_id_c  (w_free_id),
        .o_all_free_c (w_all_free)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= IDLE;
            r_sch_st        <= 1'b0;
            r_sch_inputtask <= 1'b0;
            r_sch_task_in   <= '0;
            r_done_valid    <= 1'b0;
            r_done_id       <= '0;
            r_credits       <= CRED_W'(SLOTS);
            r_drop_cnt      <= '0;
            r_err           <= 1'b0;
            r_idle_seen     <= 1'b0;
        end else begin
            r_sch_st <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (en) begin
                        r_state  <= START;
                        r_sch_st <= 1'b1;
                    end
                end
                START:   r_state <= WAIT;
                WAIT:    r_state <= RUN;
                RUN:     r_state <= RUN;
                default: r_state <= IDLE;
            endcase

            r_sch_inputtask <= w_issue;
            r_sch_task_in   <= w_issue ? in_task : '0;
            r_done_valid    <= w_free;
            r_done_id       <= w_free ? w_free_id : '0;

            if (w_drop && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + DROP_W'(1);
            end

            // Simultaneous issue and release leave the credit count unchanged.
            if (w_issue && !w_free) begin
                r_credits <= r_credits - CRED_W'(1);
            end else if (w_free && !w_issue) begin
                if (r_credits == CRED_W'(SLOTS)) begin
                    r_err <= 1'b1;
                end else begin
                    r_credits <= r_credits + CRED_W'(1);
                end
            end

            if (w_obs && !w_obs_hit) begin
                r_err <= 1'b1;
            end

            r_idle_seen <= w_idle_cond;
            if (w_idle_cond && r_idle_seen) begin
                r_err <= 1'b1;
            end
        end
    end

    assign sch_st        = r_sch_st;
    assign sch_inputtask = r_sch_inputtask;
    assign sch_task_in   = r_sch_task_in;
    assign done_valid    = r_done_valid;
    assign done_id       = r_done_id;
    assign credits       = r_credits;
    assign drop_cnt      = r_drop_cnt;
    assign err           = r_err;

endmodule

// File: tb/tb_task_feeder.sv
// Bench for task_feeder: directed scenarios plus random traffic, checked every cycle against
// a queue-based model of the in-flight set, with a round-robin scheduler stand-in closing the loop.
module tb_task_feeder;

    localparam int          SLOTS = 5;
    localparam logic [15:0] IDLE  = 16'hFFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] in_task;
    logic        sch_st;
    logic        sch_inputtask;
    logic [19:0] sch_task_in;
    logic [15:0] sch_task_out;
    logic        sch_empty;
    logic        done_valid;
    logic [15:0] done_id;
    logic [2:0]  credits;
    logic [7:0]  drop_cnt;
    logic        err;

    task_feeder dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_task       (in_task),
        .sch_st        (sch_st),
        .sch_inputtask (sch_inputtask),
        .sch_task_in   (sch_task_in),
        .sch_task_out  (sch_task_out),
        .sch_empty     (sch_empty),
        .done_valid    (done_valid),
        .done_id       (done_id),
        .credits       (credits),
        .drop_cnt      (drop_cnt),
        .err           (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] id;
        int          rem;
    } ent_t;

    int checks = 0;
    int errors = 0;

    // Model: cycles since start (-1 = not started), in-flight set, counters, expected registered outputs.
    int          m_age = -1;
    ent_t        m_q[$];
    int          m_drop = 0;
    bit          m_err = 1'b0;
    bit          m_idle_prev = 1'b0;
    bit          e_st = 1'b0;
    bit          e_inputtask = 1'b0;
    logic [19:0] e_task_in = '0;
    bit          e_done = 1'b0;
    logic [15:0] e_done_id = '0;

    // Scheduler stand-in: round-robin store, one slice per non-stalled cycle.
    ent_t sq[$];
    bit   manual = 1'b0;
    int   stall_pct = 0;

    bit          obs_ready;
    bit          obs_done;
    logic [15:0] obs_done_id;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_run();
        return m_age >= 2;
    endfunction

    function automatic bit m_legal(input logic [19:0] t);
        return (t[19:16] != 4'd0) && (t[15:0] != IDLE);
    endfunction

    function automatic bit m_has(input logic [15:0] id);
        foreach (m_q[i]) if (m_q[i].id == id) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_ready();
        if (!m_run() || !in_valid) return 1'b0;
        if (!m_legal(in_task)) return 1'b1;
        return (m_q.size() < SLOTS) && !m_has(in_task[15:0]);
    endfunction

    task automatic sched_edge();
        ent_t t;
        if (sch_task_out != IDLE && sq.size() > 0 && sq[0].id == sch_task_out) begin
            t = sq.pop_front();
            t.rem = t.rem - 1;
            if (t.rem > 0) sq.push_back(t);
        end
        if (e_inputtask) begin
            chk("sched_overrun", 32'(sq.size() < SLOTS), 32'd1);
            sq.push_back('{id: e_task_in[15:0], rem: int'(e_task_in[19:16])});
        end
    endtask

    task automatic model_edge();
        bit acc;
        bit issue;
        bit cond;
        int k;
        if (rst) begin
            m_age = -1; m_q.delete(); m_drop = 0; m_err = 1'b0; m_idle_prev = 1'b0;
            e_st = 1'b0; e_inputtask = 1'b0; e_task_in = '0; e_done = 1'b0; e_done_id = '0;
            sq.delete();
            return;
        end
        acc   = m_ready();
        issue = acc && m_legal(in_task);
        cond  = m_run() && (m_q.size() == 0) && !e_inputtask && !sch_empty;
        if (cond && m_idle_prev) m_err = 1'b1;
        m_idle_prev = cond;
        e_done = 1'b0;
        e_done_id = '0;
        if (m_run() && sch_task_out != IDLE) begin
            k = -1;
            foreach (m_q[i]) if (m_q[i].id == sch_task_out) k = i;
            if (k < 0) begin
                m_err = 1'b1;
            end else begin
                m_q[k].rem = m_q[k].rem - 1;
                if (m_q[k].rem == 0) begin
                    e_done = 1'b1;
                    e_done_id = m_q[k].id;
                    m_q.delete(k);
                end
            end
        end
        if (acc && !issue && m_drop < 255) m_drop++;
        e_inputtask = issue;
        e_task_in = issue ? in_task : 20'h0;
        if (issue) m_q.push_back('{id: in_task[15:0], rem: int'(in_task[19:16])});
        if (m_age >= 0) m_age++;
        else if (en) m_age = 0;
        e_st = (m_age == 0);
    endtask

    task automatic drive_sched();
        if (manual) return;
        if (sq.size() > 0 && int'($urandom_range(0, 99)) >= stall_pct) sch_task_out = sq[0].id;
        else sch_task_out = IDLE;
        sch_empty = (sq.size() == 0);
    endtask

    task automatic check_outputs();
        chk("sch_st", 32'(sch_st), 32'(e_st));
        chk("sch_inputtask", 32'(sch_inputtask), 32'(e_inputtask));
        if (e_inputtask) chk("sch_task_in", 32'(sch_task_in), 32'(e_task_in));
        chk("done_valid", 32'(done_valid), 32'(e_done));
        if (e_done) chk("done_id", 32'(done_id), 32'(e_done_id));
        chk("credits", 32'(credits), 32'(SLOTS - m_q.size()));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        chk("err", 32'(err), 32'(m_err));
    endtask

    // One clock: inputs are already driven; compare in_ready mid-cycle, registered outputs after the edge.
    task automatic cycle();
        @(negedge clk);
        obs_ready   = in_ready;
        obs_done    = done_valid;
        obs_done_id = done_id;
        chk("in_ready", 32'(in_ready), 32'(m_ready()));
        @(posedge clk);
        sched_edge();
        model_edge();
        #1;
        check_outputs();
        drive_sched();
    endtask

    task automatic offer(input logic [19:0] t, input int bound, output bit ok);
        ok = 1'b0;
        in_valid = 1'b1;
        in_task = t;
        for (int i = 0; i < bound && !ok; i++) begin
            cycle();
            ok = obs_ready;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            cycle();
            ok = (m_q.size() == 0) && (sq.size() == 0);
        end
        chk(nm, 32'(ok), 32'd1);
        chk({nm, "_credits"}, 32'(credits), 32'd5);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit          ok;
        bit          got;
        logic [15:0] id;
        int          r;

        rst = 1'b1; en = 1'b0; in_valid = 1'b0; in_task = '0;
        sch_task_out = IDLE; sch_empty = 1'b1;
        cycle();
        cycle();
        chk("rst_credits", 32'(credits), 32'd5);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_task_in", 32'(sch_task_in), 32'd0);
        rst = 1'b0;

        // Start sequence: one-cycle start pulse, no acceptance until two cycles later.
        en = 1'b1;
        cycle();
        chk("st_pulse", 32'(sch_st), 32'd1);
        en = 1'b0; in_valid = 1'b1; in_task = 20'h30011;
        cycle();
        chk("ready_start", 32'(obs_ready), 32'd0);
        chk("st_low", 32'(sch_st), 32'd0);
        cycle();
        chk("ready_wait", 32'(obs_ready), 32'd0);
        cycle();
        chk("ready_run", 32'(obs_ready), 32'd1);
        chk("issue_task", 32'(sch_task_in), 32'h30011);
        chk("issue_credits", 32'(credits), 32'd4);
        in_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            cycle();
            got = done_valid;
        end
        chk("t2_done_seen", 32'(got), 32'd1);
        chk("t2_done_id", 32'(done_id), 32'h0011);
        chk("t2_credits", 32'(credits), 32'd5);

        // Credit exhaustion: five issue, the sixth waits for the first completion.
        for (int k = 1; k <= 5; k++) begin
            offer({4'hF, 16'(k)}, 1, ok);
            chk("fill_accept", 32'(ok), 32'd1);
        end
        offer(20'hF0006, 1, ok);
        chk("id6_stall", 32'(ok), 32'd0);
        chk("id6_credits", 32'(credits), 32'd0);
        offer(20'hF0006, 200, ok);
        chk("id6_accept", 32'(ok), 32'd1);
        chk("id6_done", 32'(obs_done), 32'd1);
        chk("id6_done_id", 32'(obs_done_id), 32'h0001);
        drain("drain3");

        // Duplicate id stalls until the earlier instance completes.
        offer(20'h40022, 1, ok);
        chk("dup_first", 32'(ok), 32'd1);
        offer(20'h20022, 1, ok);
        chk("dup_stall", 32'(ok), 32'd0);
        offer(20'h20022, 50, ok);
        chk("dup_accept", 32'(ok), 32'd1);
        chk("dup_done", 32'(obs_done), 32'd1);
        chk("dup_done_id", 32'(obs_done_id), 32'h0022);
        drain("drain4");

        // Illegal tasks are consumed and counted, never forwarded.
        offer(20'h00005, 1, ok);
        chk("drop_zero_burst", 32'(ok), 32'd1);
        chk("drop1_no_issue", 32'(sch_inputtask), 32'd0);
        offer(20'h3FFFF, 1, ok);
        chk("drop_idle_id", 32'(ok), 32'd1);
        chk("drop2_no_issue", 32'(sch_inputtask), 32'd0);
        cycle();
        chk("drop_cnt2", 32'(drop_cnt), 32'd2);
        chk("drop_credits", 32'(credits), 32'd5);

        // Random traffic over a small id pool to provoke duplicates, drops and full stalls.
        stall_pct = 20;
        for (int n = 0; n < 3000; n++) begin
            in_valid = ($urandom_range(0, 99) < 60);
            id = 16'($urandom_range(1, 8));
            r = int'($urandom_range(0, 31));
            if (r == 0) id = IDLE;
            else if (r == 1) id = 16'($urandom);
            in_task = {4'($urandom_range(0, 15)), id};
            cycle();
        end
        drain("drain_rand");
        stall_pct = 0;

        // Drop counter saturation.
        in_valid = 1'b1; in_task = 20'h00007;
        for (int n = 0; n < 260; n++) cycle();
        in_valid = 1'b0;
        cycle();
        chk("drop_sat", 32'(drop_cnt), 32'd255);

        // Unknown slice id raises a sticky error; reset mid-flight clears everything.
        offer(20'h50033, 1, ok);
        chk("t6_issue", 32'(ok), 32'd1);
        cycle();
        cycle();
        manual = 1'b1; sch_task_out = 16'h1234; sch_empty = 1'b0;
        cycle();
        chk("bad_id_err", 32'(err), 32'd1);
        manual = 1'b0;
        drive_sched();
        for (int n = 0; n < 3; n++) cycle();
        chk("err_sticky", 32'(err), 32'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_credits", 32'(credits), 32'd5);
        chk("mid_rst_drop", 32'(drop_cnt), 32'd0);
        chk("mid_rst_done", 32'(done_valid), 32'd0);
        chk("mid_rst_inputtask", 32'(sch_inputtask), 32'd0);
        for (int n = 0; n < 6; n++) cycle();

        // Scheduler reports work while nothing is tracked: error on the second such cycle.
        en = 1'b1;
        cycle();
        en = 1'b0;
        cycle();
        cycle();
        manual = 1'b1; sch_task_out = IDLE; sch_empty = 1'b0;
        cycle();
        chk("idle_err_one", 32'(err), 32'd0);
        cycle();
        chk("idle_err_two", 32'(err), 32'd1);
        manual = 1'b0;
        drive_sched();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
